// File: rtl/multicycle_controller_if.sv
// ALU operation encoding plus the signal bundle between the multicycle
// controller (master) and the datapath / shared memory port (slave).

package Types;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } AluOp;
endpackage

interface multicycle_controller_if;
    // Datapath status and memory response toward the controller
    logic [31:0]  i_Inst;
    logic         i_IsEQ;
    logic         i_IsLT;
    logic         i_IsLTU;
    logic [1:0]   i_AddrLo;
    logic         i_MemAck;

    // Controls from the controller
    logic         o_MemReq;
    logic         o_MemWr;
    logic         o_MemAddrSel;
    logic [1:0]   o_MemSize;
    logic         o_MemUnsigned;
    logic         o_InstWrEnable;
    logic         o_PCWrEnable;
    logic [1:0]   o_PCNextSel;
    Types::AluOp  o_AluControl;
    logic [1:0]   o_OperandASel;
    logic         o_OperandBSel;
    logic         o_RegWrEnable;
    logic [1:0]   o_RegWrDataSel;
    logic         o_Trap;
    logic [1:0]   o_TrapCause;

    modport master (
        input  i_Inst, i_IsEQ, i_IsLT, i_IsLTU, i_AddrLo, i_MemAck,
        output o_MemReq, o_MemWr, o_MemAddrSel, o_MemSize, o_MemUnsigned,
               o_InstWrEnable, o_PCWrEnable, o_PCNextSel, o_AluControl,
               o_OperandASel, o_OperandBSel, o_RegWrEnable, o_RegWrDataSel,
               o_Trap, o_TrapCause
    );

    modport slave (
        output i_Inst, i_IsEQ, i_IsLT, i_IsLTU, i_AddrLo, i_MemAck,
        input  o_MemReq, o_MemWr, o_MemAddrSel, o_MemSize, o_MemUnsigned,
               o_InstWrEnable, o_PCWrEnable, o_PCNextSel, o_AluControl,
               o_OperandASel, o_OperandBSel, o_RegWrEnable, o_RegWrDataSel,
               o_Trap, o_TrapCause
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM: FETCH/DECODE/EXEC/MEMORY/WRBACK/TRAP.
// Decode results are latched in DECODE and drive the datapath selects from
// registers; handshake-dependent strobes are qualified by state and ack.

module multicycle_controller #(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    multicycle_controller_if.master bus
);
    import Types::*;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMORY, S_WRBACK, S_TRAP
    } state_t;

    typedef struct packed {
        AluOp       alu;
        logic [1:0] opa;
        logic       opb;
        logic [1:0] wbsel;
        logic       load;
        logic       store;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       rd_nz;
        logic [2:0] f3;
    } ctrl_t;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS      = 2'b10;

    // Counter holds 0..MEM_TIMEOUT-1; the last value marks the expiry cycle.
    localparam int             CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit             TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    ctrl_t            ctrl_q, ctrl_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       dec_legal;
    ctrl_t      dec_ctrl;
    logic       expired;

    assign opcode  = bus.i_Inst[6:0];
    assign rd      = bus.i_Inst[11:7];
    assign funct3  = bus.i_Inst[14:12];
    assign funct7  = bus.i_Inst[31:25];
    assign expired = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // funct3 -> ALU op; alt picks SUB/SRA for the funct7[5] variants.
    function automatic AluOp alu_from_f3(input logic [2:0] f3, input logic alt);
        AluOp op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Halfword needs bit 0 clear, word needs both low bits clear.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    // Instruction decode: legality plus the control word used from EXEC on.
    always_comb begin
        dec_legal      = 1'b0;
        dec_ctrl       = '0;
        dec_ctrl.alu   = ALU_ADD;
        dec_ctrl.f3    = funct3;
        dec_ctrl.rd_nz = (rd != 5'd0);
        case (opcode)
            7'b0110111: begin                       // LUI: 0 + imm
                dec_legal    = 1'b1;
                dec_ctrl.opa = 2'b10;
                dec_ctrl.opb = 1'b1;
            end
            7'b0010111: begin                       // AUIPC: PC + imm
                dec_legal    = 1'b1;
                dec_ctrl.opa = 2'b01;
                dec_ctrl.opb = 1'b1;
            end
            7'b1101111: begin                       // JAL
                dec_legal      = 1'b1;
                dec_ctrl.jal   = 1'b1;
                dec_ctrl.opa   = 2'b01;
                dec_ctrl.opb   = 1'b1;
                dec_ctrl.wbsel = 2'b10;
            end
            7'b1100111: begin                       // JALR: target rs1 + imm
                dec_legal      = (funct3 == 3'b000);
                dec_ctrl.jalr  = 1'b1;
                dec_ctrl.opb   = 1'b1;
                dec_ctrl.wbsel = 2'b10;
            end
            7'b1100011: begin                       // Branches
                dec_legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu    = ALU_SUB;
            end
            7'b0000011: begin                       // LB/LH/LW/LBU/LHU
                dec_legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec_ctrl.load  = 1'b1;
                dec_ctrl.opb   = 1'b1;
                dec_ctrl.wbsel = 2'b01;
            end
            7'b0100011: begin                       // SB/SH/SW
                dec_legal      = !funct3[2] && (funct3[1:0] != 2'b11);
                dec_ctrl.store = 1'b1;
                dec_ctrl.opb   = 1'b1;
            end
            7'b0010011: begin                       // OP-IMM; only shifts constrain funct7
                dec_ctrl.opb = 1'b1;
                dec_ctrl.alu = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                case (funct3)
                    3'b001:  dec_legal = (funct7 == 7'b0000000);
                    3'b101:  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: dec_legal = 1'b1;
                endcase
            end
            7'b0110011: begin                       // OP register-register
                dec_ctrl.alu = alu_from_f3(funct3, funct7[5]);
                dec_legal    = (funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state, timeout counter, trap cause and latched control word.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = cause_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_FETCH, S_MEMORY: begin
                if (bus.i_MemAck) begin
                    if (state_q == S_FETCH)  state_d = S_DECODE;
                    else if (ctrl_q.store)   state_d = S_FETCH;
                    else                     state_d = S_WRBACK;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    ctrl_d  = dec_ctrl;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (ctrl_q.branch) begin
                    state_d = S_FETCH;
                end else if (ctrl_q.load || ctrl_q.store) begin
                    if (MISALIGN_TRAP && misaligned(ctrl_q.f3, bus.i_AddrLo)) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_MEMORY;
                    end
                end else begin
                    state_d = S_WRBACK;
                end
            end
            default: state_d = S_FETCH;             // WRBACK, TRAP
        endcase
    end

    // State register; reset returns to FETCH with a clean counter and cause.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_ILLEGAL;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Output decode; reset forces everything low in the same cycle.
    always_comb begin
        bus.o_MemReq       = 1'b0;
        bus.o_MemWr        = 1'b0;
        bus.o_MemAddrSel   = 1'b0;
        bus.o_MemSize      = 2'b00;
        bus.o_MemUnsigned  = 1'b0;
        bus.o_InstWrEnable = 1'b0;
        bus.o_PCWrEnable   = 1'b0;
        bus.o_PCNextSel    = 2'b00;
        bus.o_AluControl   = ALU_ADD;
        bus.o_OperandASel  = 2'b00;
        bus.o_OperandBSel  = 1'b0;
        bus.o_RegWrEnable  = 1'b0;
        bus.o_RegWrDataSel = 2'b00;
        bus.o_Trap         = 1'b0;
        bus.o_TrapCause    = cause_q;
        if (!i_Reset) begin
            // Selects stay stable from EXEC through MEMORY/WRBACK
            bus.o_AluControl   = ctrl_q.alu;
            bus.o_OperandASel  = ctrl_q.opa;
            bus.o_OperandBSel  = ctrl_q.opb;
            bus.o_RegWrDataSel = ctrl_q.wbsel;
            case (state_q)
                S_FETCH: begin
                    bus.o_MemReq       = 1'b1;
                    bus.o_MemSize      = 2'b10;
                    bus.o_InstWrEnable = bus.i_MemAck;
                end
                S_EXEC: begin
                    if (ctrl_q.branch) begin
                        bus.o_PCWrEnable = 1'b1;
                        bus.o_PCNextSel  = branch_taken(ctrl_q.f3, bus.i_IsEQ, bus.i_IsLT, bus.i_IsLTU)
                                           ? 2'b01 : 2'b00;
                    end
                end
                S_MEMORY: begin
                    bus.o_MemReq      = 1'b1;
                    bus.o_MemAddrSel  = 1'b1;
                    bus.o_MemWr       = ctrl_q.store;
                    bus.o_MemSize     = ctrl_q.f3[1:0];
                    bus.o_MemUnsigned = ctrl_q.f3[2];
                    bus.o_PCWrEnable  = ctrl_q.store && bus.i_MemAck;
                end
                S_WRBACK: begin
                    bus.o_RegWrEnable = ctrl_q.rd_nz;
                    bus.o_PCWrEnable  = 1'b1;
                    bus.o_PCNextSel   = ctrl_q.jal ? 2'b01 : (ctrl_q.jalr ? 2'b10 : 2'b00);
                end
                S_TRAP: begin
                    bus.o_Trap       = 1'b1;
                    bus.o_PCWrEnable = 1'b1;
                    bus.o_PCNextSel  = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule
